uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter PRESCALE, default 8: clocks per serial bit; SHALL be even and >= 4.
REQ-002 Parameter DATA_WIDTH, default 8: data bits per frame.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous reset, active-high.
REQ-005 RX_IN  input  1  serial line; idle high.
REQ-006 PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 P_DATA_OUT  output  DATA_WIDTH  last good received word.
REQ-009 PAR_OUT  output  1  received parity bit of last good frame; 0 when that frame had no parity.
REQ-010 RX_DONE  output  1  one-cycle pulse: good frame received.
REQ-011 PAR_ERR  output  1  one-cycle pulse: parity mismatch.
REQ-012 STP_ERR  output  1  one-cycle pulse: stop bit sampled 0.
REQ-013 RX_BUSY  output  1  high whenever state != IDLE.

Function
REQ-014 Frame format: start bit 0, DATA_WIDTH data bits LSB first, optional parity bit, stop bit 1; each bit lasts PRESCALE clocks.
REQ-015 States: IDLE, START, DATA, PARITY, STOP; edge counter 0..PRESCALE-1; bit counter 0..DATA_WIDTH-1.
REQ-016 IDLE: RX_IN sampled 0 -> that cycle is edge 0 of the start bit; go to START with edge counter 1.
REQ-017 PAR_EN and PAR_TYP SHALL be latched in the start-detect cycle and held for the whole frame; mid-frame changes are ignored.
REQ-018 Bit value = majority of RX_IN at edges PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1 of each bit.
REQ-019 START: majority 1 -> false start; return to IDLE the cycle after edge PRESCALE/2+1; no output pulses.
REQ-020 Bit boundary at edge PRESCALE-1: counter wraps to 0 and state advances: START->DATA; DATA->DATA until bit DATA_WIDTH-1, then PARITY if PAR_EN else STOP; PARITY->STOP.
REQ-021 Parity check: even requires XOR(data, parity) = 0; odd requires 1.
REQ-022 At the end of STOP (edge PRESCALE-1) the state returns to IDLE, and in that same cycle exactly one of RX_DONE, PAR_ERR or STP_ERR is asserted, one cycle wide.
REQ-023 Error priority: STP_ERR over PAR_ERR.
REQ-024 On RX_DONE, P_DATA_OUT and PAR_OUT update in the same cycle and hold until the next RX_DONE.
REQ-025 On PAR_ERR or STP_ERR, P_DATA_OUT and PAR_OUT are unchanged.
REQ-026 Latency: with start detected at cycle T and N = 2 + DATA_WIDTH + PAR_EN bits, the result pulse is high at cycle T + N*PRESCALE.
REQ-027 Back-to-back frames: in the IDLE cycle following STOP, RX_IN = 0 SHALL be detected as a new start with no lost cycle.
REQ-028 RX_BUSY is high from T+1 through the cycle before the result pulse.

Reset
REQ-029 When reset is high at a clock edge: state = IDLE, counters = 0, P_DATA_OUT = 0, PAR_OUT = 0, all pulses and RX_BUSY = 0.
REQ-030 Reset mid-frame SHALL abort the frame with no pulse.
REQ-031 After reset deasserts, the first RX_IN = 0 seen in IDLE is treated as a start bit.
REQ-032 Reset overrides any simultaneous start detect.

Verification (PRESCALE = 8, DATA_WIDTH = 8)
REQ-033 Send 0xA5 with PAR_EN = 0, start at T -> RX_DONE high only at T+80; P_DATA_OUT = 0xA5; PAR_OUT = 0; RX_BUSY high T+1..T+79.
REQ-034 Send 0x3C with PAR_EN = 1, PAR_TYP = 0 and parity bit 0 -> RX_DONE at T+88; P_DATA_OUT = 0x3C; PAR_OUT = 0. Repeat back-to-back with 0x3D and parity bit 1 -> second RX_DONE at T+176.
REQ-035 Send 0x01 with PAR_EN = 1, PAR_TYP = 1 and parity bit 1 (wrong) -> PAR_ERR pulse at T+88; no RX_DONE; P_DATA_OUT retains its previous value.
REQ-036 Send 0x55 with stop bit 0 -> STP_ERR pulse at T+80; no RX_DONE. Send a 2-cycle low glitch on an idle line -> IDLE at T+6; no pulses.
REQ-037 Single-cycle inversion at edge 4 of data bit 3 of 0xF0 -> majority filters it; RX_DONE with P_DATA_OUT = 0xF0.
REQ-038 Reset pulse at T+40 during a frame -> all outputs 0; no pulse; a following clean 0x96 frame -> RX_DONE with P_DATA_OUT = 0x96.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with optional even/odd parity.
//
// Each serial bit lasts PRESCALE clocks (even, >= 4). A bit is resolved by
// majority vote of RX_IN at edges PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous reset, active-high
//   RX_IN       in   serial line, idle high
//   PAR_EN      in   1 = frame carries a parity bit (latched at start detect)
//   PAR_TYP     in   0 = even, 1 = odd parity (latched at start detect)
//   P_DATA_OUT  out  last good received word
//   PAR_OUT     out  parity bit of last good frame (0 if frame had none)
//   RX_DONE     out  one-cycle pulse: good frame
//   PAR_ERR     out  one-cycle pulse: parity mismatch
//   STP_ERR     out  one-cycle pulse: stop bit sampled 0 (wins over PAR_ERR)
//   RX_BUSY     out  high whenever the FSM is not IDLE
//   dbg_state   out  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA_OUT,
  output logic                  PAR_OUT,
  output logic                  RX_DONE,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  RX_BUSY,
  output logic [2:0]            dbg_state
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] EDGE_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] EDGE_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  samp_a, samp_b;
  logic                  par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bit_q, stop_bit_q;

  logic start_det, bit_end, maj_pt, maj, stop_val, par_bad;
  logic frame_end, done_set, perr_set, serr_set;

  always_comb begin
    start_det = (state == IDLE) && !RX_IN;
    bit_end   = (edge_cnt == EDGE_LAST);
    maj_pt    = (edge_cnt == EDGE_S2);
    // Third sample is taken live so the vote resolves in the third-sample cycle.
    maj       = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!RX_IN) state_next = START;
      START: begin
        // False start is decided at the vote; bit_end is checked second so the
        // vote wins when both land on the same edge (PRESCALE = 4).
        if (maj_pt && maj) state_next = IDLE;
        else if (bit_end)  state_next = DATA;
      end
      DATA:   if (bit_end && (bit_cnt == BIT_LAST))
                state_next = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    // With PRESCALE = 4 the stop vote and the bit end share an edge.
    stop_val  = maj_pt ? maj : stop_bit_q;
    par_bad   = par_en_q && ((^shift_q ^ par_bit_q) != par_typ_q);
    frame_end = (state == STOP) && bit_end;
    serr_set  = frame_end && !stop_val;
    perr_set  = frame_end && stop_val && par_bad;
    done_set  = frame_end && stop_val && !par_bad;
    RX_BUSY   = (state != IDLE);
    dbg_state = state;
  end

  // Counters, samplers and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop_bit_q <= 1'b0;
    end else if (state == IDLE) begin
      bit_cnt  <= '0;
      // The start-detect cycle is edge 0, so the next cycle is edge 1.
      edge_cnt <= start_det ? EW'(1) : '0;
      if (start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end else begin
      edge_cnt <= (bit_end || state_next == IDLE) ? '0 : edge_cnt + 1'b1;
      if (state == DATA && bit_end)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      if (edge_cnt == EDGE_S0) samp_a <= RX_IN;
      if (edge_cnt == EDGE_S1) samp_b <= RX_IN;
      if (maj_pt) begin
        case (state)
          DATA:    shift_q    <= {maj, shift_q[DATA_WIDTH-1:1]};
          PARITY:  par_bit_q  <= maj;
          STOP:    stop_bit_q <= maj;
          default: ;
        endcase
      end
    end
  end

  // Result pulses and held outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      RX_DONE    <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      P_DATA_OUT <= '0;
      PAR_OUT    <= 1'b0;
    end else begin
      RX_DONE <= done_set;
      PAR_ERR <= perr_set;
      STP_ERR <= serr_set;
      if (done_set) begin
        P_DATA_OUT <= shift_q;
        PAR_OUT    <= par_en_q & par_bit_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx with PRESCALE = 8, DATA_WIDTH = 8.
// Frames are driven one clock per step; T is the cycle whose RX_IN = 0 is seen
// in IDLE, and the result is sampled in cycle T + N*8.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA_OUT;
  logic       PAR_OUT;
  logic       RX_DONE;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       RX_BUSY;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Per-frame observations
  int         stray;
  int         busy_gaps;
  logic       r_done, r_perr, r_serr, r_busy;
  logic [7:0] r_data;
  logic       r_par;
  int         pulses;

  uart_rx #(.PRESCALE(8), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA_OUT (P_DATA_OUT),
    .PAR_OUT    (PAR_OUT),
    .RX_DONE    (RX_DONE),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR),
    .RX_BUSY    (RX_BUSY),
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one complete frame; cycle k of the loop is cycle T+k.
  // glitch_at inverts the line in that one cycle; abort_at pulses reset in it.
  task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input int glitch_at,
                            input int abort_at, input logic flip_cfg);
    logic [10:0] fb;
    int n;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = data[i];
    if (pen) begin
      fb[9] = pbit; fb[10] = sbit; n = 11;
    end else begin
      fb[9] = sbit; n = 10;
    end
    stray = 0; busy_gaps = 0;
    r_done = 1'b0; r_perr = 1'b0; r_serr = 1'b0; r_busy = 1'b1;
    r_data = 8'h00; r_par = 1'b0;
    PAR_EN = pen;
    PAR_TYP = ptyp;
    for (int k = 0; k < n * 8; k++) begin
      RX_IN = fb[k/8] ^ logic'(k == glitch_at);
      reset = logic'(k == abort_at);
      tick();
      reset = 1'b0;
      if (k == abort_at) break;
      // Config inputs change after start detect and must be ignored.
      if (k == 0 && flip_cfg) begin
        PAR_EN = ~pen;
        PAR_TYP = ~ptyp;
      end
      if (k < n * 8 - 1) begin
        if (RX_DONE || PAR_ERR || STP_ERR) stray++;
        if (!RX_BUSY) busy_gaps++;
      end else begin
        r_done = RX_DONE; r_perr = PAR_ERR; r_serr = STP_ERR;
        r_busy = RX_BUSY; r_data = P_DATA_OUT; r_par = PAR_OUT;
      end
    end
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
  endtask

  task automatic idle_count(input int cycles);
    pulses = 0;
    RX_IN = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (RX_DONE || PAR_ERR || STP_ERR) pulses++;
    end
  endtask

  initial begin
    // Reset; RX_IN low on the last reset edge must not start a frame
    reset = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) tick();
    RX_IN = 1'b0;
    tick();
    reset = 1'b0;
    RX_IN = 1'b1;
    check("rst_data", P_DATA_OUT, 8'h00);
    check("rst_par", PAR_OUT, 1'b0);
    check("rst_pulses", {RX_DONE, PAR_ERR, STP_ERR}, 3'b000);
    check("rst_busy", RX_BUSY, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    idle_count(4);
    check("rst_idle_pulses", pulses, 0);

    // 0xA5 without parity: result at T+80
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    check("a5_stray", stray, 0);
    check("a5_busy_gaps", busy_gaps, 0);
    check("a5_busy_end", r_busy, 1'b0);
    check("a5_pulses", {r_done, r_perr, r_serr}, 3'b100);
    check("a5_data", r_data, 8'hA5);
    check("a5_par", r_par, 1'b0);
    tick();
    check("a5_pulse_width", RX_DONE, 1'b0);
    idle_count(3);

    // 0x3C even parity bit 0 (config flipped mid-frame), then 0x3D back-to-back
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
    check("3c_stray", stray, 0);
    check("3c_busy_gaps", busy_gaps, 0);
    check("3c_pulses", {r_done, r_perr, r_serr}, 3'b100);
    check("3c_data", r_data, 8'h3C);
    check("3c_par", r_par, 1'b0);
    send_frame(8'h3D, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
    check("3d_stray", stray, 0);
    check("3d_pulses", {r_done, r_perr, r_serr}, 3'b100);
    check("3d_data", r_data, 8'h3D);
    check("3d_par", r_par, 1'b1);
    idle_count(3);

    // 0x01 odd parity with wrong parity bit 1
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
    check("01_stray", stray, 0);
    check("01_pulses", {r_done, r_perr, r_serr}, 3'b010);
    check("01_data_held", r_data, 8'h3D);
    check("01_par_held", r_par, 1'b1);
    idle_count(3);

    // 0x55 with stop bit 0
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    check("55_stray", stray, 0);
    check("55_pulses", {r_done, r_perr, r_serr}, 3'b001);
    check("55_data_held", r_data, 8'h3D);
    idle_count(12);

    // Parity error and stop error together: stop error wins
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0);
    check("prio_pulses", {r_done, r_perr, r_serr}, 3'b001);
    idle_count(12);

    // Two-cycle low glitch: START through T+5, IDLE at T+6, no pulses
    RX_IN = 1'b0;
    tick();
    tick();
    RX_IN = 1'b1;
    repeat (3) tick();
    check("glitch_busy_t5", RX_BUSY, 1'b1);
    tick();
    check("glitch_busy_t6", RX_BUSY, 1'b0);
    check("glitch_state_t6", dbg_state, 3'd0);
    idle_count(20);
    check("glitch_pulses", pulses, 0);

    // 0xF0 with a one-cycle inversion at edge 4 of data bit 3 (cycle T+36)
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 36, -1, 1'b0);
    check("f0_stray", stray, 0);
    check("f0_pulses", {r_done, r_perr, r_serr}, 3'b100);
    check("f0_data", r_data, 8'hF0);
    idle_count(3);

    // Reset at T+40 aborts the frame, then a clean 0x96
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, 40, 1'b0);
    check("abort_data", P_DATA_OUT, 8'h00);
    check("abort_par", PAR_OUT, 1'b0);
    check("abort_pulses", {RX_DONE, PAR_ERR, STP_ERR}, 3'b000);
    check("abort_busy", RX_BUSY, 1'b0);
    idle_count(60);
    check("abort_idle_pulses", pulses, 0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    check("96_stray", stray, 0);
    check("96_pulses", {r_done, r_perr, r_serr}, 3'b100);
    check("96_data", r_data, 8'h96);
    idle_count(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
